// File: rtl/stat_readback_pkg.sv
// Shared types and helpers for the status read-back responder.
// Optional read-clear pulses are enabled by STAT_READBACK_READ_CLEAR_EN.
package stat_readback_pkg;

   localparam int IPB_DATA_W = 32;
   localparam int MAX_NREG   = 16;
   localparam int SEL_W      = 4;

   typedef enum logic [2:0] {
      IDLE,
      SNAP,
      ACK,
      ERR,
      WAIT
   } state_t;

   // Word k sits at bit offset 32*k, so the index shifted left by 5 is the base.
   function automatic logic [IPB_DATA_W-1:0] word_sel(
      input logic [MAX_NREG*IPB_DATA_W-1:0] vec,
      input logic [SEL_W-1:0]               idx
   );
      return vec[{idx, 5'd0} +: IPB_DATA_W];
   endfunction

endpackage

// File: rtl/stat_readback_if.sv
// IPbus-style read/write handshake between the slave fabric and a register responder.
// Shared by every build, with or without STAT_READBACK_READ_CLEAR_EN.
interface stat_readback_if #(
   parameter int ADDR_W = 4
);
   import stat_readback_pkg::*;

   logic                  ipb_strobe;
   logic                  ipb_write;
   logic [ADDR_W-1:0]     ipb_addr;
   logic [IPB_DATA_W-1:0] ipb_rdata;
   logic                  ipb_ack;
   logic                  ipb_err;

   modport master (
      output ipb_strobe,
      output ipb_write,
      output ipb_addr,
      input  ipb_rdata,
      input  ipb_ack,
      input  ipb_err
   );

   modport slave (
      input  ipb_strobe,
      input  ipb_write,
      input  ipb_addr,
      output ipb_rdata,
      output ipb_ack,
      output ipb_err
   );

endinterface

// File: rtl/stat_readback_snap_reg32.sv
// 32-bit snapshot register: all bits load together on one edge when capture is high.
// Used identically with or without STAT_READBACK_READ_CLEAR_EN.
module snap_reg32 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        capture,
   input  logic [31:0] d,
   output logic [31:0] q
);

   logic [31:0] q_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_reg <= '0;
      end else if (capture) begin
         q_reg <= d;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/stat_readback.sv
// Read-only responder: snapshots one of NREG live status words per IPbus read, rejects writes/out-of-range.
// Define STAT_READBACK_READ_CLEAR_EN to add the one-hot stat_clr pulse issued with each ack.
module stat_readback
   import stat_readback_pkg::*;
#(
   parameter int NREG   = 8,
   parameter int ADDR_W = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   stat_readback_if.slave             ipb,
   input  logic [NREG*IPB_DATA_W-1:0] stat_in
`ifdef STAT_READBACK_READ_CLEAR_EN
   ,
   output logic [NREG-1:0]            stat_clr
`endif
);

   localparam logic [ADDR_W:0] NREG_LIM = (ADDR_W+1)'(NREG);

   state_t                  state_reg;
   state_t                  state_next;
   logic [ADDR_W-1:0]       addr_q_reg;
   logic                    addr_load;
   logic                    capture;
   logic                    addr_ok;
   logic                    ack_reg;
   logic                    err_reg;
   logic [IPB_DATA_W-1:0]   snap_word;
   logic [IPB_DATA_W-1:0]   rdata_q;
   logic [MAX_NREG*IPB_DATA_W-1:0] stat_ext;

   assign addr_ok = ({1'b0, ipb.ipb_addr} < NREG_LIM);

   always_comb begin
      state_next = state_reg;
      addr_load  = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (ipb.ipb_strobe) begin
               if (!ipb.ipb_write && addr_ok) begin
                  addr_load  = 1'b1;
                  state_next = SNAP;
               end else begin
                  state_next = ERR;
               end
            end
         end
         SNAP: begin
            if (ipb.ipb_strobe) begin
               capture    = 1'b1;
               state_next = ACK;
            end else begin
               state_next = IDLE;
            end
         end
         ACK:  state_next = WAIT;
         ERR:  state_next = WAIT;
         WAIT: begin
            if (!ipb.ipb_strobe) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ack/err are decoded from the state register one edge later so they leave the block from flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         addr_q_reg <= '0;
         ack_reg    <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (addr_load) begin
            addr_q_reg <= ipb.ipb_addr;
         end
         ack_reg <= (state_reg == ACK);
         err_reg <= (state_reg == ERR);
      end
   end

   assign stat_ext  = (MAX_NREG*IPB_DATA_W)'(stat_in);
   assign snap_word = word_sel(stat_ext, SEL_W'(addr_q_reg));

   snap_reg32 u_snap (
      .clk     (clk),
      .reset_n (reset_n),
      .capture (capture),
      .d       (snap_word),
      .q       (rdata_q)
   );

   assign ipb.ipb_rdata = rdata_q;
   assign ipb.ipb_ack   = ack_reg;
   assign ipb.ipb_err   = err_reg;

`ifdef STAT_READBACK_READ_CLEAR_EN
   logic [NREG-1:0] clr_next;
   logic [NREG-1:0] clr_reg;

   for (genvar gi = 0; gi < NREG; gi++) begin : g_clr
      assign clr_next[gi] = (state_reg == ACK) && (addr_q_reg == ADDR_W'(gi));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clr_reg <= '0;
      end else begin
         clr_reg <= clr_next;
      end
   end

   assign stat_clr = clr_reg;
`endif

endmodule

// File: tb/tb_stat_readback.sv
// Bench for stat_readback: vector table plus snapshot and reset sequences, scoreboard-checked.
// Exercises stat_clr as well when STAT_READBACK_READ_CLEAR_EN is defined.
module tb_stat_readback;

   localparam int NREG   = 8;
   localparam int ADDR_W = 4;

   typedef enum int {K_ACK = 0, K_ERR = 1, K_NONE = 2} kind_t;

   typedef struct {
      int          addr;
      bit          wr;
      bit          abort;
      int          hold;
      kind_t       kind;
      logic [31:0] data;
   } vec_t;

   typedef struct {
      kind_t       kind;
      logic [31:0] data;
      int          addr;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic [NREG*32-1:0]   stat_in;
   logic [31:0]          stat_arr [NREG];
   logic                 inc_en;
   logic [31:0]          cnt5;
`ifdef STAT_READBACK_READ_CLEAR_EN
   logic [NREG-1:0]      stat_clr;
`endif

   int   n_vec  = 0;
   int   n_miss = 0;
   exp_t sb [$];
   vec_t vecs [11];

   always #5 clk = ~clk;

   stat_readback_if #(.ADDR_W(ADDR_W)) ipb ();

   stat_readback #(
      .NREG   (NREG),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .ipb      (ipb),
      .stat_in  (stat_in)
`ifdef STAT_READBACK_READ_CLEAR_EN
      ,
      .stat_clr (stat_clr)
`endif
   );

   // Word 5 is a live counter when inc_en is set, parked at 0x10 otherwise.
   always @(posedge clk) cnt5 <= inc_en ? cnt5 + 32'd1 : 32'h10;

   always_comb begin
      stat_in = '0;
      for (int k = 0; k < NREG; k++) begin
         stat_in[k*32 +: 32] = (k == 5) ? cnt5 : stat_arr[k];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   task automatic do_txn(input vec_t v, input bit snap_cnt);
      exp_t e;
      int   n;
      int   resp;
      bit   seen;
      e.kind = v.kind;
      e.data = v.data;
      e.addr = v.addr;
      sb.push_back(e);
      ipb.ipb_strobe = 1'b1;
      ipb.ipb_addr   = ADDR_W'(v.addr);
      ipb.ipb_write  = v.wr;
      tick();
      n = 1;
      check("early_resp", {30'd0, ipb.ipb_ack, ipb.ipb_err}, 32'd0);
      if (snap_cnt) sb[sb.size()-1].data = cnt5;
      if (v.abort) begin
         ipb.ipb_strobe = 1'b0;
         for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_resp", {30'd0, ipb.ipb_ack, ipb.ipb_err}, 32'd0);
`ifdef STAT_READBACK_READ_CLEAR_EN
            check("abort_clr", 32'(stat_clr), 32'd0);
`endif
         end
         e = sb.pop_front();
         check("abort_rdata", ipb.ipb_rdata, e.data);
         $display("txn addr=%0d write=%0b abort -> rdata=%h", v.addr, v.wr, ipb.ipb_rdata);
         return;
      end
      seen = 1'b0;
      while (!seen && n < 10) begin
         tick();
         n++;
         seen = ipb.ipb_ack || ipb.ipb_err;
      end
      e = sb.pop_front();
      if (!seen) begin
         n_vec++;
         n_miss++;
         $display("FAIL timeout: no ack/err for addr=%0d within %0d cycles", v.addr, n);
         ipb.ipb_strobe = 1'b0;
         tick();
         tick();
         return;
      end
      resp = (ipb.ipb_ack && ipb.ipb_err) ? 3 : ipb.ipb_ack ? 0 : 1;
      check("resp_kind", resp, e.kind);
      check("latency", n, (e.kind == K_ACK) ? 3 : 2);
      check("rdata", ipb.ipb_rdata, e.data);
`ifdef STAT_READBACK_READ_CLEAR_EN
      check("clr_pulse", 32'(stat_clr),
            (e.kind == K_ACK) ? 32'(NREG'(1) << e.addr) : 32'd0);
`endif
      for (int i = 0; i < v.hold; i++) begin
         tick();
         check("hold_resp", {30'd0, ipb.ipb_ack, ipb.ipb_err}, 32'd0);
         check("hold_rdata", ipb.ipb_rdata, e.data);
      end
      ipb.ipb_strobe = 1'b0;
      tick();
      check("post_resp", {30'd0, ipb.ipb_ack, ipb.ipb_err}, 32'd0);
`ifdef STAT_READBACK_READ_CLEAR_EN
      check("post_clr", 32'(stat_clr), 32'd0);
`endif
      $display("txn addr=%0d write=%0b -> resp=%0d latency=%0d rdata=%h",
               v.addr, v.wr, resp, n, ipb.ipb_rdata);
   endtask

   initial begin
      vec_t v;
      reset_n        = 1'b0;
      inc_en         = 1'b0;
      ipb.ipb_strobe = 1'b0;
      ipb.ipb_write  = 1'b0;
      ipb.ipb_addr   = '0;
      stat_arr[0] = 32'h11111111;
      stat_arr[1] = 32'h22220001;
      stat_arr[2] = 32'h33330002;
      stat_arr[3] = 32'hDEADBEEF;
      stat_arr[4] = 32'h44444444;
      stat_arr[5] = 32'h0;
      stat_arr[6] = 32'h66666666;
      stat_arr[7] = 32'hFFFFFFFF;

      //          addr wr abort hold kind    expected rdata
      vecs[0]  = '{3,  0, 0,    0,   K_ACK,  32'hDEADBEEF};
      vecs[1]  = '{0,  0, 0,    1,   K_ACK,  32'h11111111};
      vecs[2]  = '{7,  0, 0,    0,   K_ACK,  32'hFFFFFFFF};
      vecs[3]  = '{8,  0, 0,    0,   K_ERR,  32'hFFFFFFFF};
      vecs[4]  = '{0,  1, 0,    1,   K_ERR,  32'hFFFFFFFF};
      vecs[5]  = '{2,  0, 0,    0,   K_ACK,  32'h33330002};
      vecs[6]  = '{15, 0, 0,    0,   K_ERR,  32'h33330002};
      vecs[7]  = '{2,  0, 1,    0,   K_NONE, 32'h33330002};
      vecs[8]  = '{6,  0, 0,    3,   K_ACK,  32'h66666666};
      vecs[9]  = '{5,  0, 0,    0,   K_ACK,  32'h00000010};
      vecs[10] = '{1,  1, 0,    0,   K_ERR,  32'h00000010};

      repeat (3) tick();
      check("reset_ack", 32'(ipb.ipb_ack), 32'd0);
      check("reset_err", 32'(ipb.ipb_err), 32'd0);
      check("reset_rdata", ipb.ipb_rdata, 32'd0);
`ifdef STAT_READBACK_READ_CLEAR_EN
      check("reset_clr", 32'(stat_clr), 32'd0);
`endif
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) begin
         do_txn(vecs[i], 1'b0);
      end

      // Snapshot of a counter that moves every cycle; hold keeps WAIT long enough to see it not follow.
      inc_en = 1'b1;
      tick();
      tick();
      v = '{5, 0, 0, 3, K_ACK, 32'h0};
      do_txn(v, 1'b1);
      inc_en = 1'b0;
      tick();

      // Reset while ack is high, strobe kept high through reset release.
      ipb.ipb_strobe = 1'b1;
      ipb.ipb_addr   = ADDR_W'(4);
      ipb.ipb_write  = 1'b0;
      repeat (3) tick();
      check("pre_reset_ack", 32'(ipb.ipb_ack), 32'd1);
      reset_n = 1'b0;
      #1;
      check("async_ack", 32'(ipb.ipb_ack), 32'd0);
      check("async_err", 32'(ipb.ipb_err), 32'd0);
      check("async_rdata", ipb.ipb_rdata, 32'd0);
`ifdef STAT_READBACK_READ_CLEAR_EN
      check("async_clr", 32'(stat_clr), 32'd0);
`endif
      tick();
      tick();
      reset_n = 1'b1;
      v = '{4, 0, 0, 0, K_ACK, 32'h44444444};
      do_txn(v, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
